prbs_seq_ctrl: RTL and testbench
================================

PRBS_SEQ_CTRL -- requirements
Module: prbs_seq_ctrl

Interface
REQ-001 The block SHALL have the parameter LEN_W, default 16, which sets the width of the payload length field.
REQ-002 CLK  input  1  the single clock; every register SHALL update on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to run one burst; it SHALL be sampled only in IDLE.
REQ-005 abort  input  1  terminates an active burst.
REQ-006 cfg_word  input  32  preamble word and seed; bits [14:0] are the LFSR seed.
REQ-007 cfg_n  input  8  number of preamble word repetitions.
REQ-008 cfg_len  input  LEN_W  number of LFSR payload bytes after the preamble.
REQ-009 prbs_byte  input  8  registered byte output of the PRBS generator.
REQ-010 prbs_rstn  output  1  active-low reset to the generator; it SHALL be registered.
REQ-011 prbs_in  output  32  latched cfg_word, driven to the generator.
REQ-012 prbs_n  output  8  latched cfg_n, driven to the generator.
REQ-013 data_out  output  8  equal to prbs_byte, combinational pass-through.
REQ-014 data_valid  output  1  data_out holds a burst byte; it SHALL be registered.
REQ-015 preamble  output  1  the valid byte is a preamble byte; it SHALL be registered.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a burst completes normally.
REQ-018 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-019 The block SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-020 IDLE: prbs_rstn=0 and data_valid=0.
  - A start with cfg_n!=0 and cfg_word[14:0]!=0 SHALL latch prbs_in, prbs_n and the length, then go to LOAD.
REQ-021 Rejected start: a start in IDLE with cfg_n==0 or cfg_word[14:0]==0 SHALL stay in IDLE and pulse err the next cycle.
  - This avoids the 256-repetition case and the all-zero LFSR lockup.
REQ-022 LOAD: one cycle with prbs_rstn held 0 so the generator loads the new seed; then go to RUN, with prbs_rstn registered to 1 on that edge.
REQ-023 Burst length: the total byte count SHALL be T = 4*cfg_n + cfg_len.
  - The counter SHALL be wide enough for 4*255 + (2^LEN_W - 1) without overflow (17 bits at default).
REQ-024 First valid byte: data_valid SHALL first assert in the second RUN cycle, which is the first cycle the generator drives in[31:24].
REQ-025 Valid run: data_valid SHALL then stay high for exactly T consecutive cycles.
REQ-026 Preamble flag: preamble SHALL be high in the first 4*cfg_n valid cycles and low in the remaining cfg_len valid cycles.
REQ-027 End of RUN: after the T-th valid cycle, the next cycle SHALL be DONE with data_valid=0 and prbs_rstn=0.
REQ-028 DONE: done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-029 Preamble-only burst: cfg_len==0 is legal; T=4*cfg_n and the block SHALL emit no payload bytes.
REQ-030 start while busy SHALL be ignored, with no err pulse and no change to the latched configuration.
REQ-031 abort in LOAD or RUN SHALL, on the next cycle:
  - set the state to IDLE;
  - drive data_valid=0, preamble=0 and prbs_rstn=0;
  - not pulse done.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 Simultaneous abort and the final valid cycle: abort SHALL take priority and done SHALL NOT pulse.
REQ-034 Simultaneous start and abort in IDLE: start SHALL be processed.
REQ-035 Changes to cfg_* while busy SHALL NOT affect the running burst.

Reset
REQ-036 RST=1 at a clock edge SHALL force:
  - state=IDLE;
  - prbs_rstn=0, prbs_in=0, prbs_n=0;
  - data_valid=0, preamble=0, busy=0, done=0, err=0;
  - the byte counter to 0.
REQ-037 RST SHALL take priority over start and abort; RST asserted mid-burst SHALL behave as reset with no done pulse.
REQ-038 The first start SHALL be accepted on the first edge after RST deasserts.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
  - Nominal burst: cfg_word=0xA1B2C3D4, cfg_n=1, cfg_len=3, start -> 7 valid bytes A1,B2,C3,D4 (preamble=1), then D4,A9,52 (preamble=0); done pulses the cycle after 0x52.
  - Preamble only: cfg_n=2, cfg_len=0 -> 8 valid bytes, 2x the preamble word, preamble=1 throughout, then done.
  - Rejects: start with cfg_n=0, and separately with cfg_word=0xFFFF8000 (seed zero) -> err pulse, busy stays 0, prbs_rstn stays 0.
  - Abort: abort on the 3rd valid cycle -> data_valid=0 and prbs_rstn=0 next cycle, no done; a following start runs a full burst correctly.
  - Ignored start: start held high continuously through a burst, with cfg changed mid-burst -> burst unchanged; a new burst starts from IDLE one cycle after DONE.
  - Reset mid-burst: RST pulsed during RUN -> all outputs reach their reset values on the next cycle, and no done pulse.

Source files
------------

// File: rtl/prbs_seq_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_seq_ctrl
//
// Sequences one burst of an external PRBS generator: a preamble made of
// cfg_n repetitions of the 32-bit cfg_word, followed by cfg_len LFSR payload
// bytes. The controller latches the configuration, holds the generator in
// reset for one LOAD cycle so it picks up the new seed, then releases it and
// flags every byte the generator produces until the burst total is reached.
//
// Ports
//   CLK         rising-edge clock for every register
//   RST         synchronous, active-high reset
//   start       one-cycle burst request, only looked at in IDLE
//   abort       cancels a burst that is in LOAD or RUN
//   cfg_word    preamble word; bits [14:0] also seed the LFSR
//   cfg_n       number of preamble word repetitions (0 is rejected)
//   cfg_len     number of payload bytes after the preamble (0 is legal)
//   prbs_byte   registered byte coming back from the generator
//   prbs_rstn   registered active-low reset to the generator
//   prbs_in     latched cfg_word driven to the generator
//   prbs_n      latched cfg_n driven to the generator
//   data_out    prbs_byte passed straight through
//   data_valid  data_out carries a burst byte
//   preamble    the valid byte belongs to the preamble
//   busy        controller is anywhere but IDLE
//   done        one-cycle pulse on normal burst completion
//   err         one-cycle pulse when a start is rejected
// ---------------------------------------------------------------------------
module prbs_seq_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_word,
    input  logic [7:0]       cfg_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [7:0]       prbs_byte,
    output logic             prbs_rstn,
    output logic [31:0]      prbs_in,
    output logic [7:0]       prbs_n,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             preamble,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The byte counter must hold 4*255 (10 bits) plus the largest payload
    // length without wrapping, so it is one bit wider than the larger of the
    // two operands.
    localparam int CNT_W = ((LEN_W > 10) ? LEN_W : 10) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [CNT_W-1:0]   total_q,    total_d;
    logic [CNT_W-1:0]   pre_q,      pre_d;
    logic [31:0]        prbs_in_q,  prbs_in_d;
    logic [7:0]         prbs_n_q,   prbs_n_d;
    logic               rstn_q,     rstn_d;
    logic               valid_q,    valid_d;
    logic               preamble_q, preamble_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic               cfg_ok;

    // A repetition count of zero would look like 256 repetitions to the
    // generator, and an all-zero seed locks the LFSR, so both are refused.
    assign cfg_ok = (cfg_n != 8'd0) && (cfg_word[14:0] != 15'd0);

    // Next-state and next-output logic. Every output is computed here one
    // cycle ahead and registered below. In RUN, cnt_q counts the valid bytes
    // already flagged: while it is below the total we flag one more byte,
    // and once it equals the total the burst ends. The generator only starts
    // producing bytes one cycle after its reset is released, which is why the
    // first RUN cycle (cnt_q still 0 with data_valid low) lines up with the
    // first preamble byte appearing on the following cycle. Abort is checked
    // before the end-of-burst test so that it suppresses done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        pre_d      = pre_q;
        prbs_in_d  = prbs_in_q;
        prbs_n_d   = prbs_n_q;
        rstn_d     = 1'b0;
        valid_d    = 1'b0;
        preamble_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        prbs_in_d = cfg_word;
                        prbs_n_d  = cfg_n;
                        pre_d     = CNT_W'({cfg_n, 2'b00});
                        total_d   = CNT_W'({cfg_n, 2'b00}) + CNT_W'(cfg_len);
                        cnt_d     = '0;
                        state_d   = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rstn_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == total_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rstn_d     = 1'b1;
                    valid_d    = 1'b1;
                    preamble_d = (cnt_q < pre_q);
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset wins over everything else and
    // returns the controller to IDLE with the generator held in reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            total_q    <= '0;
            pre_q      <= '0;
            prbs_in_q  <= '0;
            prbs_n_q   <= '0;
            rstn_q     <= 1'b0;
            valid_q    <= 1'b0;
            preamble_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            pre_q      <= pre_d;
            prbs_in_q  <= prbs_in_d;
            prbs_n_q   <= prbs_n_d;
            rstn_q     <= rstn_d;
            valid_q    <= valid_d;
            preamble_q <= preamble_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign prbs_rstn  = rstn_q;
    assign prbs_in    = prbs_in_q;
    assign prbs_n     = prbs_n_q;
    assign data_out   = prbs_byte;
    assign data_valid = valid_q;
    assign preamble   = preamble_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs_seq_ctrl
//
// Drives prbs_seq_ctrl through directed and randomised bursts. A small
// behavioural PRBS generator sits on the generator side of the controller;
// the expected byte stream of each burst is built up front from the burst
// rules (preamble word bytes, then x^15+x^14+1 LFSR bytes) and compared with
// what the controller flags as valid, cycle by cycle.
// ---------------------------------------------------------------------------
module tb_prbs_seq_ctrl;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic [31:0] cfg_word;
    logic [7:0]  cfg_n;
    logic [15:0] cfg_len;
    logic [7:0]  prbs_byte;
    logic        prbs_rstn;
    logic [31:0] prbs_in;
    logic [7:0]  prbs_n;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        preamble;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0] expQ[$];

    prbs_seq_ctrl #(.LEN_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .cfg_word   (cfg_word),
        .cfg_n      (cfg_n),
        .cfg_len    (cfg_len),
        .prbs_byte  (prbs_byte),
        .prbs_rstn  (prbs_rstn),
        .prbs_in    (prbs_in),
        .prbs_n     (prbs_n),
        .data_out   (data_out),
        .data_valid (data_valid),
        .preamble   (preamble),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural generator: while held in reset it loads the word and seed;
    // once released it registers the preamble bytes MSB first, prbs_n times,
    // and then the low byte of a left-shifting x^15+x^14+1 LFSR.
    logic [31:0] genWord;
    logic [14:0] genLfsr;
    logic [7:0]  genByte;
    int          genIdx = 0;

    always @(posedge CLK) begin
        if (prbs_rstn !== 1'b1) begin
            genWord <= prbs_in;
            genLfsr <= prbs_in[14:0];
            genIdx  <= 0;
            genByte <= 8'd0;
        end else begin
            if (genIdx < 4 * int'(prbs_n)) begin
                genByte <= genWord[31 - 8 * (genIdx % 4) -: 8];
            end else begin
                genByte <= genLfsr[7:0];
                genLfsr <= {genLfsr[13:0], genLfsr[14] ^ genLfsr[13]};
            end
            genIdx <= genIdx + 1;
        end
    end

    assign prbs_byte = genByte;

    // Safety net so a stuck run still terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic [31:0] w,
                                 input logic [7:0] n, input logic [15:0] l);
        start    = s;
        abort    = a;
        cfg_word = w;
        cfg_n    = n;
        cfg_len  = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: preamble word bytes repeated n times, then len bytes
    // of the LFSR computed with integer arithmetic from the seed.
    task automatic buildExpected(input logic [31:0] w, input logic [7:0] n, input logic [15:0] l);
        int s;
        expQ.delete();
        for (int r = 0; r < int'(n); r++) begin
            for (int b = 0; b < 4; b++) begin
                expQ.push_back(8'((w >> (24 - 8 * b)) & 32'hFF));
            end
        end
        s = int'(w & 32'h7FFF);
        for (int i = 0; i < int'(l); i++) begin
            expQ.push_back(8'(s & 255));
            s = ((s * 2) & 32'h7FFE) | (((s / 16384) + (s / 8192)) % 2);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, 32'(data_valid), 32'd0);
        checkOutput({tag, "_pre"},   32'(preamble),   32'd0);
        checkOutput({tag, "_busy"},  32'(busy),       32'd0);
        checkOutput({tag, "_done"},  32'(done),       32'd0);
        checkOutput({tag, "_err"},   32'(err),        32'd0);
        checkOutput({tag, "_rstn"},  32'(prbs_rstn),  32'd0);
        checkOutput({tag, "_in"},    prbs_in,         32'd0);
        checkOutput({tag, "_n"},     32'(prbs_n),     32'd0);
    endtask

    // One full burst from IDLE. abortAt >= 0 raises abort during that valid
    // byte index; holdStart keeps start high and rewrites cfg mid-burst;
    // withAbort raises abort together with the accepting start.
    task automatic runBurst(input logic [31:0] w, input logic [7:0] n, input logic [15:0] l,
                            input int abortAt, input bit holdStart, input bit withAbort);
        int          total;
        int          npre;
        bit          aborted;
        logic [31:0] newWord;
        logic [7:0]  newN;
        newWord = 32'd0;
        newN    = 8'd0;
        aborted = 1'b0;
        buildExpected(w, n, l);
        total = expQ.size();
        npre  = 4 * int'(n);

        applyStimulus(1'b1, withAbort, w, n, l);
        stepCycle();
        if (!holdStart) start = 1'b0;
        abort = 1'b0;
        checkOutput("load_busy",  32'(busy),       32'd1);
        checkOutput("load_rstn",  32'(prbs_rstn),  32'd0);
        checkOutput("load_valid", 32'(data_valid), 32'd0);
        checkOutput("load_in",    prbs_in,         w);
        checkOutput("load_n",     32'(prbs_n),     32'(n));

        stepCycle();
        checkOutput("run0_valid", 32'(data_valid), 32'd0);
        checkOutput("run0_rstn",  32'(prbs_rstn),  32'd1);

        for (int i = 0; i < total && !aborted; i++) begin
            stepCycle();
            checkOutput("valid",     32'(data_valid), 32'd1);
            checkOutput("byte",      32'(data_out),   32'(expQ[i]));
            checkOutput("preamble",  32'(preamble),   (i < npre) ? 32'd1 : 32'd0);
            checkOutput("run_done",  32'(done),       32'd0);
            checkOutput("run_err",   32'(err),        32'd0);
            if (holdStart && i == 1) begin
                newWord = $urandom | 32'd1;
                newN    = 8'($urandom_range(1, 3));
                cfg_word = newWord;
                cfg_n    = newN;
                cfg_len  = 16'($urandom_range(0, 9));
            end
            if (i == abortAt) begin
                abort = 1'b1;
                stepCycle();
                abort = 1'b0;
                aborted = 1'b1;
                checkOutput("abort_valid", 32'(data_valid), 32'd0);
                checkOutput("abort_rstn",  32'(prbs_rstn),  32'd0);
                checkOutput("abort_pre",   32'(preamble),   32'd0);
                checkOutput("abort_busy",  32'(busy),       32'd0);
                checkOutput("abort_done",  32'(done),       32'd0);
                stepCycle();
                checkOutput("abort_done2", 32'(done),       32'd0);
            end
        end

        if (!aborted) begin
            stepCycle();
            checkOutput("end_valid", 32'(data_valid), 32'd0);
            checkOutput("end_rstn",  32'(prbs_rstn),  32'd0);
            checkOutput("end_done",  32'(done),       32'd1);
            checkOutput("end_busy",  32'(busy),       32'd1);
            stepCycle();
            checkOutput("idle_done", 32'(done),       32'd0);
            checkOutput("idle_busy", 32'(busy),       32'd0);
            if (holdStart) begin
                stepCycle();
                checkOutput("restart_busy", 32'(busy),    32'd1);
                checkOutput("restart_in",   prbs_in,      newWord);
                checkOutput("restart_n",    32'(prbs_n),  32'(newN));
                start = 1'b0;
                abort = 1'b1;
                stepCycle();
                abort = 1'b0;
                checkOutput("loadabort_busy", 32'(busy),      32'd0);
                checkOutput("loadabort_rstn", 32'(prbs_rstn), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  n;
        logic [15:0] l;
        int          ab;

        $display("[TB] prbs_seq_ctrl bench starting");

        // Reset held with start and abort active: reset must win.
        RST = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'hA1B2C3D4, 8'd1, 16'd3);
        stepCycle();
        stepCycle();
        checkReset("reset");

        // Nominal burst, start on the first edge after reset release.
        RST = 1'b0;
        runBurst(32'hA1B2C3D4, 8'd1, 16'd3, -1, 1'b0, 1'b0);

        // Preamble-only burst.
        runBurst(32'h5A6B7C8D, 8'd2, 16'd0, -1, 1'b0, 1'b0);

        // Rejected starts: zero repetitions, then zero seed.
        applyStimulus(1'b1, 1'b0, 32'h12345678, 8'd0, 16'd4);
        stepCycle();
        start = 1'b0;
        checkOutput("rej_n_err",  32'(err),       32'd1);
        checkOutput("rej_n_busy", 32'(busy),      32'd0);
        checkOutput("rej_n_rstn", 32'(prbs_rstn), 32'd0);
        stepCycle();
        checkOutput("rej_n_err2", 32'(err),       32'd0);
        checkOutput("rej_n_busy2", 32'(busy),     32'd0);

        applyStimulus(1'b1, 1'b0, 32'hFFFF8000, 8'd3, 16'd4);
        stepCycle();
        start = 1'b0;
        checkOutput("rej_s_err",  32'(err),       32'd1);
        checkOutput("rej_s_busy", 32'(busy),      32'd0);
        checkOutput("rej_s_rstn", 32'(prbs_rstn), 32'd0);
        stepCycle();
        checkOutput("rej_s_err2", 32'(err),       32'd0);

        // Abort in IDLE does nothing.
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);
        checkOutput("idle_abort_err",  32'(err),  32'd0);

        // Abort on the third valid byte, then a clean full burst.
        runBurst(32'hCAFE1234, 8'd1, 16'd5, 2, 1'b0, 1'b0);
        runBurst(32'hCAFE1234, 8'd1, 16'd5, -1, 1'b0, 1'b0);

        // Abort on the final valid byte suppresses done.
        runBurst(32'h0BADF00D, 8'd1, 16'd2, 5, 1'b0, 1'b0);

        // Start held through a burst with cfg rewritten mid-burst.
        runBurst(32'h13579BDF, 8'd2, 16'd4, -1, 1'b1, 1'b0);

        // Start and abort together in IDLE: start wins.
        runBurst(32'h2468ACE1, 8'd1, 16'd1, -1, 1'b0, 1'b1);

        // Reset during RUN.
        applyStimulus(1'b1, 1'b0, 32'h89ABCDEF, 8'd2, 16'd5);
        stepCycle();
        start = 1'b0;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("pre_rst_valid", 32'(data_valid), 32'd1);
        RST = 1'b1;
        stepCycle();
        checkReset("midrst");
        RST = 1'b0;
        stepCycle();
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        runBurst(32'h89ABCDEF, 8'd1, 16'd2, -1, 1'b0, 1'b0);

        // Randomised bursts, some aborted part-way.
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            if (w[14:0] == 15'd0) w[0] = 1'b1;
            n = 8'($urandom_range(1, 4));
            l = 16'($urandom_range(0, 20));
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4 * int'(n) + int'(l) - 1) : -1;
            runBurst(w, n, l, ab, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
